fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage that sits upstream of the decoder/control unit.
//   Holds the PC and fetches each word from a handshaked instruction memory.
//   Presents the word to decode and holds it until execution completes.
//   Then applies the Pcsrc redirect from the control unit: sequential, branch or jump.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC loaded on reset
//   ACK_TIMEOUT  16             max cycles Imem_req may wait for Imem_ack before fault
//   ICNT_W       32             width of retired-instruction counter
// PORTS
//   Clk         in   1       single clock, rising edge
//   Rst         in   1       synchronous, active-high reset
//   Imem_req    out  1       fetch request to instruction memory
//   Imem_addr   out  32      fetch address (= Pc while Imem_req)
//   Imem_ack    in   1       memory accepts request; Imem_rdata valid same cycle
//   Imem_rdata  in   32      instruction word
//   Inst        out  32      held instruction to decoder (Op=Inst[31:26], Func=Inst[5:0])
//   Inst_valid  out  1       Inst is valid, execution in progress
//   Ex_done     in   1       datapath finished current instruction; Pcsrc valid this cycle
//   Pcsrc       in   2       00 seq, 10 branch taken, 11 jump, 01 reserved (treated as 00)
//   Pc          out  32      PC of current instruction
//   Pc4         out  32      Pc + 4
//   Fault       out  1       sticky: memory ack timeout
//   Icount      out  ICNT_W  retired-instruction count
// BEHAVIOUR
//   Reset (Rst sampled 1): Pc=RESET_PC, Inst=0, Inst_valid=0, Imem_req=0, Fault=0,
//     Icount=0, timer=0, state=IDLE. Reset mid-operation aborts all: in-flight ack/rdata discarded.
//   FSM states: IDLE, REQ, EXEC, FAULT.
//     IDLE: one cycle after reset release -> REQ.
//     REQ: Imem_req=1, Imem_addr=Pc. On edge with Imem_ack=1: Inst<=Imem_rdata,
//       Inst_valid<=1, timer<=0 -> EXEC. Else timer++; timer reaching ACK_TIMEOUT
//       (ACK_TIMEOUT cycles without ack) -> FAULT.
//     EXEC: Imem_req=0, Inst held stable. On edge with Ex_done=1: Pc<=next_pc,
//       Icount++, Inst_valid<=0 -> REQ. Ex_done=0: hold indefinitely (no timeout).
//     FAULT: Imem_req=0, Inst_valid=0, Fault=1; exits only by Rst.
//   next_pc (32-bit, wrap modulo 2^32, no overflow flag):
//     00/01: Pc4
//     10:    Pc4 + ({{14{Inst[15]}},Inst[15:0],2'b00})
//     11:    {Pc4[31:28], Inst[25:0], 2'b00}
//   Imem_ack outside REQ ignored; Ex_done outside EXEC ignored.
//   Ack on the same edge the timer would expire: ack wins -> EXEC.
//   Icount wraps to 0 after all-ones; no saturation.
//   Latency: reset release -> Imem_req high 2nd cycle; zero-wait ack -> Inst_valid next
//     cycle; Ex_done -> Imem_req with new Pc next cycle. Min 2 cycles/instruction.
//   Pc4 is combinational from Pc; all other outputs registered or decoded from state.
// STRUCTURE
//   Shared package (cpu_pkg): Pcsrc encodings PCSRC_SEQ=2'b00, PCSRC_BR=2'b10,
//     PCSRC_J=2'b11; fetch FSM state enum; instruction field slice constants
//     (OP, FUNC, IMM16, TARGET26).
//   One sub-module: next_pc_calc (combinational: Pc, Inst, Pcsrc -> next_pc, Pc4).
//   FSM, timeout timer, Inst register and Icount live in fetch_unit.
// TESTING
//   1 Reset: Rst high 3 cycles, release -> Pc=0, Imem_req=0 first cycle, 1 next,
//     Imem_addr=0, Icount=0, Fault=0.
//   2 Sequential with waits: ack after 2 wait cycles with rdata=32'h2001_0005 ->
//     Inst=32'h2001_0005, Inst_valid=1; Ex_done, Pcsrc=00 -> Pc=4, Icount=1.
//   3 Branch back: Pc=8, Inst=32'h1000_FFFE, Ex_done with Pcsrc=10 -> Pc=32'h4;
//     repeat with Pcsrc=01 -> Pc=32'hC.
//   4 Jump: Pc=32'h10, Inst=32'h0800_0010, Pcsrc=11 -> Pc=32'h40, Imem_addr=32'h40 next cycle.
//   5 Timeout: hold Imem_ack=0 for 16 cycles in REQ -> Fault=1, Imem_req=0, late ack ignored;
//     ack exactly on 16th cycle -> no fault, EXEC.
//   6 Reset mid-op: Rst during REQ and during EXEC with Ex_done=1 -> Pc=RESET_PC,
//     Icount unchanged from 0, Inst_valid=0; Icount wrap with ICNT_W=4 after 16 retires -> 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: Pcsrc encodings, fetch FSM states, instruction field slices.
// Also provides the branch offset helper used by the next-PC logic.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_RSV = 2'b01,
        PCSRC_BR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_EXEC  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNC_MSB  = 5;
    localparam int FUNC_LSB  = 0;
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    localparam int TGT26_MSB = 25;
    localparam int TGT26_LSB = 0;

    // Word offset: sign-extended 16-bit immediate scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake, decode/execute handshake and status.
// master = fetch_unit side, slave = memory/datapath side.
interface fetch_unit_if #(
    parameter int ICNT_W = 32
);
    logic              Imem_req;
    logic [31:0]       Imem_addr;
    logic              Imem_ack;
    logic [31:0]       Imem_rdata;
    logic [31:0]       Inst;
    logic              Inst_valid;
    logic              Ex_done;
    logic [1:0]        Pcsrc;
    logic [31:0]       Pc;
    logic [31:0]       Pc4;
    logic              Fault;
    logic [ICNT_W-1:0] Icount;

    modport master (
        output Imem_req, Imem_addr, Inst, Inst_valid, Pc, Pc4, Fault, Icount,
        input  Imem_ack, Imem_rdata, Ex_done, Pcsrc
    );

    modport slave (
        input  Imem_req, Imem_addr, Inst, Inst_valid, Pc, Pc4, Fault, Icount,
        output Imem_ack, Imem_rdata, Ex_done, Pcsrc
    );
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC select: sequential, PC-relative branch or region-local jump.
// Only the low 26 instruction bits matter here, so only those are brought in.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0]        pc_i,
    input  logic [TGT26_MSB:0] inst_i,
    input  logic [1:0]         pcsrc_i,
    output logic [31:0]        pc4_o,
    output logic [31:0]        next_pc_o
);
    always_comb begin
        pc4_o     = pc_i + 32'd4;
        next_pc_o = pc4_o;
        case (pcsrc_i)
            PCSRC_BR: next_pc_o = pc4_o + branch_offset(inst_i[IMM16_MSB:IMM16_LSB]);
            PCSRC_J:  next_pc_o = {pc4_o[31:28], inst_i[TGT26_MSB:TGT26_LSB], 2'b00};
            default:  next_pc_o = pc4_o;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: request word at Pc, hold it for decode until Ex_done, then redirect Pc.
// Min 2 cycles/instruction; stalls on missing ack (faults after ACK_TIMEOUT) or missing Ex_done.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          ICNT_W      = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    fetch_unit_if.master bus
);
    localparam int                TMR_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    fetch_state_e      state_q;
    logic [31:0]       pc_q;
    logic [31:0]       inst_q;
    logic              inst_valid_q;
    logic [TMR_W-1:0]  timer_q;
    logic [ICNT_W-1:0] icount_q;
    logic [31:0]       next_pc_d;
    logic [31:0]       pc4;

    next_pc_calc u_next_pc (
        .pc_i      (pc_q),
        .inst_i    (inst_q[TGT26_MSB:0]),
        .pcsrc_i   (bus.Pcsrc),
        .pc4_o     (pc4),
        .next_pc_o (next_pc_d)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            timer_q      <= '0;
            icount_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_REQ;
                ST_REQ: begin
                    // An ack on the expiring cycle still counts as a hit.
                    if (bus.Imem_ack) begin
                        inst_q       <= bus.Imem_rdata;
                        inst_valid_q <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= ST_EXEC;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        if (timer_q == TMR_LAST) begin
                            state_q <= ST_FAULT;
                        end
                    end
                end
                ST_EXEC: begin
                    if (bus.Ex_done) begin
                        pc_q         <= next_pc_d;
                        icount_q     <= icount_q + 1'b1;
                        inst_valid_q <= 1'b0;
                        state_q      <= ST_REQ;
                    end
                end
                ST_FAULT: inst_valid_q <= 1'b0;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.Imem_req   = (state_q == ST_REQ);
    assign bus.Imem_addr  = pc_q;
    assign bus.Inst       = inst_q;
    assign bus.Inst_valid = inst_valid_q;
    assign bus.Pc         = pc_q;
    assign bus.Pc4        = pc4;
    assign bus.Fault      = (state_q == ST_FAULT);
    assign bus.Icount     = icount_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed boundary cases plus randomized instruction stream.
module tb_fetch_unit;
    localparam int ICW = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exec_t;

    logic Clk = 1'b0;
    logic Rst;

    fetch_unit_if #(.ICNT_W(ICW)) bus ();

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (16),
        .ICNT_W      (ICW)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr_q[$];
    exec_t       exp_exec_q[$];
    exec_t       mon_e;
    logic        ack_live = 1'b0;
    logic        ex_live  = 1'b0;
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    // Reference next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               input logic [1:0] src);
        logic signed [15:0] imm;
        int                 off;
        imm = w[15:0];
        off = int'(imm) * 4;
        case (src)
            2'b10:   return pc + 32'd4 + off;
            2'b11:   return ((pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
            default: return pc + 32'd4;
        endcase
    endfunction

    // Monitor: pops expectations whenever a live handshake is visible.
    always @(negedge Clk) begin
        if (ack_live && bus.Imem_ack) begin
            if (exp_addr_q.size() == 0) begin
                fail("addr_q_underflow");
            end else begin
                check("fetch_req", 32'(bus.Imem_req), 32'd1);
                check("fetch_addr", bus.Imem_addr, exp_addr_q.pop_front());
            end
        end
        if (ex_live && bus.Ex_done) begin
            if (exp_exec_q.size() == 0) begin
                fail("exec_q_underflow");
            end else begin
                mon_e = exp_exec_q.pop_front();
                check("exec_inst_valid", 32'(bus.Inst_valid), 32'd1);
                check("exec_inst", bus.Inst, mon_e.inst);
                check("exec_pc", bus.Pc, mon_e.pc);
                check("exec_pc4", bus.Pc4, mon_e.pc + 32'd4);
                check("exec_icount", 32'(bus.Icount), mon_e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Imem_req) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        fail("req_timeout");
    endtask

    task automatic do_fetch(input logic [31:0] word, input int ack_wait);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        exp_addr_q.push_back(m_pc);
        repeat (ack_wait) begin
            bus.Imem_ack = 1'b0;
            bus.Ex_done  = 1'($urandom);
            bus.Pcsrc    = 2'($urandom);
            tick();
        end
        bus.Ex_done    = 1'b0;
        bus.Imem_ack   = 1'b1;
        bus.Imem_rdata = word;
        ack_live       = 1'b1;
        tick();
        ack_live       = 1'b0;
        bus.Imem_ack   = 1'b0;
        bus.Imem_rdata = $urandom;
        check("inst_valid_after_ack", 32'(bus.Inst_valid), 32'd1);
    endtask

    task automatic do_instr(input logic [31:0] word, input int ack_wait, input int ex_wait,
                            input logic [1:0] src);
        exec_t e;
        do_fetch(word, ack_wait);
        e.inst = word;
        e.pc   = m_pc;
        e.cnt  = 32'(m_cnt);
        exp_exec_q.push_back(e);
        repeat (ex_wait) begin
            bus.Imem_ack   = 1'($urandom);
            bus.Imem_rdata = $urandom;
            tick();
        end
        bus.Imem_ack = 1'b0;
        bus.Ex_done  = 1'b1;
        bus.Pcsrc    = src;
        ex_live      = 1'b1;
        tick();
        ex_live      = 1'b0;
        bus.Ex_done  = 1'b0;
        bus.Pcsrc    = 2'($urandom);
        m_pc  = model_next(m_pc, word, src);
        m_cnt = (m_cnt + 1) % (1 << ICW);
        check("req_after_done", 32'(bus.Imem_req), 32'd1);
    endtask

    task automatic apply_reset(input int n);
        Rst          = 1'b1;
        bus.Imem_ack = 1'b0;
        bus.Ex_done  = 1'b0;
        bus.Pcsrc    = 2'b00;
        repeat (n) tick();
        Rst   = 1'b0;
        m_pc  = 32'h0;
        m_cnt = 0;
        exp_addr_q.delete();
        exp_exec_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Imem_rdata = 32'h0;
        apply_reset(3);
        check("rst_req_first", 32'(bus.Imem_req), 32'd0);
        check("rst_pc", bus.Pc, 32'h0);
        check("rst_icount", 32'(bus.Icount), 32'd0);
        check("rst_fault", 32'(bus.Fault), 32'd0);
        check("rst_inst_valid", 32'(bus.Inst_valid), 32'd0);
        check("rst_inst", bus.Inst, 32'h0);
        tick();
        check("rst_req_second", 32'(bus.Imem_req), 32'd1);
        check("rst_addr", bus.Imem_addr, 32'h0);

        do_instr(32'h2001_0005, 2, 1, 2'b00);
        check("seq_pc", bus.Pc, 32'h4);
        check("seq_icount", 32'(bus.Icount), 32'd1);

        do_instr($urandom, 0, 0, 2'b00);
        do_instr(32'h1000_FFFE, 0, 1, 2'b10);
        check("branch_back_pc", bus.Pc, 32'h4);
        do_instr($urandom, 0, 0, 2'b00);
        do_instr(32'h1000_FFFE, 1, 0, 2'b01);
        check("reserved_pcsrc_pc", bus.Pc, 32'hC);

        do_instr($urandom, 0, 0, 2'b00);
        do_instr(32'h0800_0010, 0, 0, 2'b11);
        check("jump_addr", bus.Imem_addr, 32'h40);

        for (int i = 0; i < 40; i++) begin
            do_instr($urandom,
                     ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 2'($urandom));
        end

        // Ack timeout: 16 REQ cycles without ack.
        apply_reset(2);
        tick();
        repeat (15) tick();
        check("pre_timeout_fault", 32'(bus.Fault), 32'd0);
        check("pre_timeout_req", 32'(bus.Imem_req), 32'd1);
        tick();
        check("timeout_fault", 32'(bus.Fault), 32'd1);
        check("timeout_req", 32'(bus.Imem_req), 32'd0);
        bus.Imem_ack   = 1'b1;
        bus.Imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.Imem_ack = 1'b0;
        bus.Ex_done  = 1'b1;
        tick();
        bus.Ex_done = 1'b0;
        check("fault_sticky", 32'(bus.Fault), 32'd1);
        check("fault_inst_valid", 32'(bus.Inst_valid), 32'd0);
        check("fault_pc", bus.Pc, 32'h0);
        check("fault_icount", 32'(bus.Icount), 32'd0);

        apply_reset(1);
        do_instr(32'h1234_5678, 15, 0, 2'b00);
        check("ack_on_last_cycle_fault", 32'(bus.Fault), 32'd0);

        // Reset during REQ with an ack in flight.
        apply_reset(1);
        tick();
        Rst            = 1'b1;
        bus.Imem_ack   = 1'b1;
        bus.Imem_rdata = 32'hCAFE_F00D;
        tick();
        Rst          = 1'b0;
        bus.Imem_ack = 1'b0;
        check("rst_req_inst_valid", 32'(bus.Inst_valid), 32'd0);
        check("rst_req_pc", bus.Pc, 32'h0);
        check("rst_req_inst", bus.Inst, 32'h0);

        // Reset during EXEC with Ex_done high.
        do_fetch(32'h0800_0100, 0);
        Rst         = 1'b1;
        bus.Ex_done = 1'b1;
        bus.Pcsrc   = 2'b11;
        tick();
        Rst         = 1'b0;
        bus.Ex_done = 1'b0;
        check("rst_exec_pc", bus.Pc, 32'h0);
        check("rst_exec_icount", 32'(bus.Icount), 32'd0);
        check("rst_exec_inst_valid", 32'(bus.Inst_valid), 32'd0);
        m_pc  = 32'h0;
        m_cnt = 0;

        for (int i = 0; i < 16; i++) begin
            do_instr($urandom, 0, 0, 2'($urandom));
        end
        check("icount_wrap", 32'(bus.Icount), 32'd0);

        tick();
        if (exp_addr_q.size() != 0 || exp_exec_q.size() != 0) fail("scoreboard_not_drained");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
